decode_67b_framer: RTL

//  Parametrised 64B/67B-style receive framer: block-lock search, bit-slip alignment,

---
 rtl/decode_67b_framer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_67b_framer.sv
// Receive framer for 67-bit blocks: header-lock search by bit slip,
// payload de-inversion and windowed header-error monitoring.
module decode_67b_framer #(
  parameter int DATA_W        = 64,
  parameter int GOOD_SYNC_CNT = 64,
  parameter int ERR_WINDOW    = 64,
  parameter int ERR_LIMIT     = 16,
  parameter int SLIP_WAIT     = 2,
  parameter bit INVERT_EN     = 1'b1
) (
  input  logic              USER_CLK,
  input  logic              SYSTEM_RESET,
  input  logic [DATA_W+2:0] DATA_IN,
  input  logic              DATA_IN_VALID,
  input  logic              PASSTHROUGH,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [1:0]        HEADER_OUT,
  output logic              DATA_OUT_VALID,
  output logic              HEADER_ERR,
  output logic              LOCKED,
  output logic [6:0]        CANDIDATE,
  output logic              LOCK_LOSS,
  output logic [15:0]       BAD_HDR_CNT
);

  localparam int FW = DATA_W + 3;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_SLIP = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam logic [6:0]  LAST_CAND = 7'(FW - 1);
  localparam logic [15:0] GOOD_LAST = 16'(GOOD_SYNC_CNT - 1);
  localparam logic [15:0] WIN_LAST  = 16'(ERR_WINDOW - 1);
  localparam logic [15:0] ERR_LAST  = 16'(ERR_LIMIT - 1);
  localparam logic [3:0]  WAIT_LAST = 4'(SLIP_WAIT - 1);

  logic [FW-1:0]     r_rx;
  logic [2*FW-1:0]   r_common;
  logic              r_primed;
  logic              r_v1;
  logic [1:0]        r_state;
  logic [6:0]        r_cand;
  logic [15:0]       r_good;
  logic [15:0]       r_win;
  logic [15:0]       r_err;
  logic [3:0]        r_wait;
  logic [15:0]       r_bad_cnt;
  logic              r_lock_loss;
  logic [DATA_W-1:0] r_data_out;
  logic [1:0]        r_hdr_out;
  logic              r_dvalid;
  logic              r_hdr_err;

  logic [FW-1:0]     w_aligned;
  logic              w_hdr_ok;
  logic [DATA_W-1:0] w_payload;
  logic              w_eval;
  logic [6:0]        w_cand_inc;

  logic [1:0]        w_state_n;
  logic [6:0]        w_cand_n;
  logic [15:0]       w_good_n;
  logic [15:0]       w_win_n;
  logic [15:0]       w_err_n;
  logic [3:0]        w_wait_n;
  logic [15:0]       w_bad_n;
  logic              w_loss_n;

  // Offset k picks k trailing bits of the older word plus the top of the newer.
  assign w_aligned = r_common[r_cand +: FW];
  assign w_hdr_ok  = w_aligned[FW-2] ^ w_aligned[FW-3];
  assign w_payload = (INVERT_EN && w_aligned[FW-1])
                   ? ~w_aligned[DATA_W-1:0]
                   :  w_aligned[DATA_W-1:0];

  // The aligned word is judged once, when the next valid word arrives.
  assign w_eval     = DATA_IN_VALID && r_primed && !PASSTHROUGH;
  assign w_cand_inc = (r_cand == LAST_CAND) ? 7'd0 : r_cand + 7'd1;

  always_comb begin
    w_state_n = r_state;
    w_cand_n  = r_cand;
    w_good_n  = r_good;
    w_win_n   = r_win;
    w_err_n   = r_err;
    w_wait_n  = r_wait;
    w_bad_n   = r_bad_cnt;
    w_loss_n  = 1'b0;
    if (PASSTHROUGH) begin
      w_state_n = ST_SYNC;
      w_cand_n  = 7'd0;
      w_good_n  = 16'd0;
      w_win_n   = 16'd0;
      w_err_n   = 16'd0;
      w_wait_n  = 4'd0;
    end else if (w_eval) begin
      unique case (1'b1)
        (r_state == ST_SYNC): begin
          if (w_hdr_ok) begin
            if (r_good == GOOD_LAST) begin
              w_state_n = ST_LOCK;
              w_good_n  = 16'd0;
              w_win_n   = 16'd0;
              w_err_n   = 16'd0;
            end else begin
              w_good_n = r_good + 16'd1;
            end
          end else begin
            w_good_n  = 16'd0;
            w_cand_n  = w_cand_inc;
            w_wait_n  = 4'd0;
            w_state_n = (SLIP_WAIT == 0) ? ST_SYNC : ST_SLIP;
          end
        end
        (r_state == ST_SLIP): begin
          if (r_wait == WAIT_LAST) begin
            w_wait_n  = 4'd0;
            w_state_n = ST_SYNC;
          end else begin
            w_wait_n = r_wait + 4'd1;
          end
        end
        (r_state == ST_LOCK): begin
          if (!w_hdr_ok && r_bad_cnt != 16'hFFFF)
            w_bad_n = r_bad_cnt + 16'd1;
          // The error limit wins over a window that ends on the same word.
          if (!w_hdr_ok && r_err == ERR_LAST) begin
            w_state_n = ST_SYNC;
            w_loss_n  = 1'b1;
            w_good_n  = 16'd0;
            w_win_n   = 16'd0;
            w_err_n   = 16'd0;
            w_wait_n  = 4'd0;
          end else if (r_win == WIN_LAST) begin
            w_win_n = 16'd0;
            w_err_n = 16'd0;
          end else begin
            w_win_n = r_win + 16'd1;
            if (!w_hdr_ok)
              w_err_n = r_err + 16'd1;
          end
        end
        default: begin
          w_state_n = ST_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      r_rx        <= '0;
      r_common    <= '0;
      r_primed    <= 1'b0;
      r_v1        <= 1'b0;
      r_state     <= ST_SYNC;
      r_cand      <= 7'd0;
      r_good      <= 16'd0;
      r_win       <= 16'd0;
      r_err       <= 16'd0;
      r_wait      <= 4'd0;
      r_bad_cnt   <= 16'd0;
      r_lock_loss <= 1'b0;
      r_data_out  <= '0;
      r_hdr_out   <= 2'b00;
      r_dvalid    <= 1'b0;
      r_hdr_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cand      <= w_cand_n;
      r_good      <= w_good_n;
      r_win       <= w_win_n;
      r_err       <= w_err_n;
      r_wait      <= w_wait_n;
      r_bad_cnt   <= w_bad_n;
      r_lock_loss <= w_loss_n;
      r_v1        <= DATA_IN_VALID;
      if (DATA_IN_VALID) begin
        r_rx     <= DATA_IN;
        r_common <= {r_rx, DATA_IN};
        r_primed <= 1'b1;
      end
      r_dvalid <= r_v1 && ((r_state == ST_LOCK) || PASSTHROUGH);
      if (r_v1) begin
        r_data_out <= w_payload;
        r_hdr_out  <= w_aligned[FW-2:FW-3];
        r_hdr_err  <= !w_hdr_ok;
      end
    end
  end

  assign DATA_OUT       = r_data_out;
  assign HEADER_OUT     = r_hdr_out;
  assign DATA_OUT_VALID = r_dvalid;
  assign HEADER_ERR     = r_hdr_err;
  assign LOCKED         = (r_state == ST_LOCK);
  assign CANDIDATE      = r_cand;
  assign LOCK_LOSS      = r_lock_loss;
  assign BAD_HDR_CNT    = r_bad_cnt;

endmodule
